mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the ARM pipeline. Sits directly downstream of the EXE/MEM pipeline register and upstream of the MEM/WB register.
- Consumes the EXE/MEM outputs: control bits, ALU result used as the address, Rm value used as store data, and destination.
- Performs data-memory reads and writes against an internal word memory that has a configurable access latency.
- Raises freeze so the upstream pipeline registers hold while an access is in flight.

Parameters:
- DEPTH, 64: number of 32-bit data-memory words; must be a power of two.
- BASE_ADDR, 1024: byte address that maps to word 0.
- WAIT_CYCLES, 3: cycles freeze stays high per access, from 0 to 15. A value of 0 gives a single-cycle access.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- writebackEnabledIn  in  1  writeback enable from EXE/MEM.
- memoryReadEnabledIn  in  1  load request.
- memoryWriteEnabledIn  in  1  store request.
- aluResultIn  in  32  byte address, or ALU result for non-memory instructions.
- valRmIn  in  32  store data.
- destinationIn  in  4  destination register index.
- writebackEnabled  out  1  writeback enable to MEM/WB.
- memoryReadEnabled  out  1  selects memData at writeback.
- aluResult  out  32  passthrough of aluResultIn.
- memData  out  32  load data.
- destination  out  4  passthrough of destinationIn.
- freeze  out  1  stall request to the upstream pipeline registers and the hazard unit.

Behaviour:
- Reset: synchronous, active-low; rst is sampled on the clk rising edge.
  - While rst=0: state=IDLE, counter=0, memData=0, freeze=0, writebackEnabled=0, memoryReadEnabled=0.
  - Memory array contents are not reset.
- Request:
  - req = memoryReadEnabledIn | memoryWriteEnabledIn.
  - If both read and write are set, the write wins and the read is ignored.
- Address:
  - idx = ((aluResultIn - BASE_ADDR) >> 2) mod DEPTH.
  - Bits [1:0] are ignored.
  - Out-of-range addresses wrap and are not flagged.
- FSM for WAIT_CYCLES > 0, with states IDLE, BUSY, DONE:
  - IDLE, req=0: stay in IDLE; freeze=0.
  - IDLE, req=1: freeze=1 combinationally in the same cycle; counter <= WAIT_CYCLES-1; next state is BUSY, or DONE directly if WAIT_CYCLES=1.
  - BUSY: freeze=1; counter decrements each cycle.
  - BUSY, counter=0 at the clock edge: commit the write (mem[idx] <= valRmIn), or capture the read (memData <= mem[idx]); next state is DONE.
  - In the WAIT_CYCLES=1 case the commit or capture happens on the IDLE->DONE edge.
  - DONE: freeze=0; memData is valid.
  - DONE: next state is IDLE unconditionally. The request still visible in DONE is the completed one and must not restart.
  - Net effect: freeze is high for exactly WAIT_CYCLES cycles per access, followed by one DONE cycle.
  - Back-to-back accesses therefore produce the freeze pattern 1,1,1,0 repeated (WAIT_CYCLES=3).
- Inputs must stay stable while freeze=1; upstream holds them, and the block does not check this.
- WAIT_CYCLES = 0:
  - The FSM stays in IDLE and freeze is always 0.
  - A write commits at the edge where req is present.
  - memData = mem[idx] combinationally.
- Outputs:
  - writebackEnabled = writebackEnabledIn & ~freeze.
  - memoryReadEnabled = memoryReadEnabledIn & ~memoryWriteEnabledIn & ~freeze.
  - aluResult and destination are pure passthroughs.
- Reset mid-access: state returns to IDLE and the pending write is discarded; memory is left unchanged.
- Non-memory instructions (req=0): zero latency; no state change.

Optional Feature:
- Macro: MEM_STAT_EN.
- When defined:
  - Adds output accessCount (16 bits), incremented on each committed read or write.
  - Saturates at 0xFFFF and clears on reset.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan (WAIT_CYCLES=3, BASE_ADDR=1024, DEPTH=64):
1. Reset:
   - Stimulus: rst=0 for 2 cycles with memoryReadEnabledIn=1.
   - Response: freeze=0, memData=0, writebackEnabled=0.
   - After release, the read starts fresh and freeze goes 1,1,1,0.
2. Store then load:
   - Stimulus: write 0xDEADBEEF at 1028, then a read of 1028 with writebackEnabledIn=1.
   - Response: freeze=1 for 3 cycles on each access.
   - In the read's DONE cycle: memData=0xDEADBEEF, writebackEnabled=1, memoryReadEnabled=1.
3. Back-to-back reads of 1024 and 1032:
   - Response: freeze sequence 1,1,1,0,1,1,1,0; each DONE cycle shows the correct word.
4. Non-memory instruction:
   - Stimulus: writebackEnabledIn=1, req=0, aluResultIn=0x12345678, destinationIn=5.
   - Response: freeze=0; outputs pass through in the same cycle; writebackEnabled=1.
5. Reset mid-write:
   - Stimulus: write 0x1 to 1036 (old value 0x0), with rst=0 at the second BUSY cycle.
   - Response: a later read of 1036 returns 0x0.
6. Wrap and conflict:
   - Stimulus: write 0xA5 at 1024+4*64, then read 1024.
   - Response: the read returns 0xA5.
   - Stimulus: both enables set together.
   - Response: the write is performed, and memoryReadEnabled=0 in DONE.

Source files
------------

// File: rtl/mem_stage_if.sv
// EXE/MEM to MEM/WB bundle seen by the memory stage.
// MEM_STAT_EN adds the accessCount statistic output.
interface mem_stage_if;
  logic        writebackEnabledIn;
  logic        memoryReadEnabledIn;
  logic        memoryWriteEnabledIn;
  logic [31:0] aluResultIn;
  logic [31:0] valRmIn;
  logic [3:0]  destinationIn;
  logic        writebackEnabled;
  logic        memoryReadEnabled;
  logic [31:0] aluResult;
  logic [31:0] memData;
  logic [3:0]  destination;
  logic        freeze;
`ifdef MEM_STAT_EN
  logic [15:0] accessCount;
`endif

  modport master (
    output writebackEnabledIn,
    output memoryReadEnabledIn,
    output memoryWriteEnabledIn,
    output aluResultIn,
    output valRmIn,
    output destinationIn,
`ifdef MEM_STAT_EN
    input  accessCount,
`endif
    input  writebackEnabled,
    input  memoryReadEnabled,
    input  aluResult,
    input  memData,
    input  destination,
    input  freeze
  );

  modport slave (
    input  writebackEnabledIn,
    input  memoryReadEnabledIn,
    input  memoryWriteEnabledIn,
    input  aluResultIn,
    input  valRmIn,
    input  destinationIn,
`ifdef MEM_STAT_EN
    output accessCount,
`endif
    output writebackEnabled,
    output memoryReadEnabled,
    output aluResult,
    output memData,
    output destination,
    output freeze
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: word data memory with WAIT_CYCLES latency and freeze.
// MEM_STAT_EN adds a saturating committed-access counter.
module mem_stage #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          wr;
  logic          rd;
  logic          req;
  logic          commit;
  logic          freeze_w;
  logic [31:0]   rdata_w;
  logic          freeze;

  assign idx = AW'((bus.aluResultIn - 32'(BASE_ADDR)) >> 2);
  assign wr  = bus.memoryWriteEnabledIn;
  assign rd  = bus.memoryReadEnabledIn & ~wr;
  assign req = wr | bus.memoryReadEnabledIn;

  if (WAIT_CYCLES == 0) begin : g_comb
    assign commit   = req;
    assign freeze_w = 1'b0;
    assign rdata_w  = mem_q[idx];
  end else begin : g_fsm
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam state_t     FIRST    =
      (WAIT_CYCLES == 1) ? DONE : BUSY;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;

    always_comb begin
      commit   = 1'b0;
      freeze_w = 1'b0;
      unique case (state_q)
        IDLE: begin
          freeze_w = req;
          commit   = req && (WAIT_CYCLES == 1);
        end
        BUSY: begin
          freeze_w = 1'b1;
          commit   = (cnt_q == 4'd1);
        end
        default: ;
      endcase
    end

    // DONE always returns to IDLE: its request is the finished one
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        rdata_q <= '0;
      end else begin
        if (commit && rd)
          rdata_q <= mem_q[idx];
        unique case (state_q)
          IDLE: begin
            if (req) begin
              cnt_q   <= CNT_INIT;
              state_q <= FIRST;
            end
          end
          BUSY: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1)
              state_q <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

    assign rdata_w = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst && commit && wr)
      mem_q[idx] <= bus.valRmIn;
  end

  assign freeze = rst & freeze_w;

  assign bus.freeze            = freeze;
  assign bus.writebackEnabled  =
    rst & bus.writebackEnabledIn & ~freeze;
  assign bus.memoryReadEnabled = rst & rd & ~freeze;
  assign bus.memData           = rst ? rdata_w : '0;
  assign bus.aluResult         = bus.aluResultIn;
  assign bus.destination       = bus.destinationIn;

`ifdef MEM_STAT_EN
  logic [15:0] acc_q;

  always_ff @(posedge clk) begin
    if (!rst)
      acc_q <= '0;
    else if (commit && acc_q != 16'hFFFF)
      acc_q <= acc_q + 16'd1;
  end

  assign bus.accessCount = acc_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (WAIT_CYCLES=3, BASE_ADDR=1024).
// Each access is held for freeze cycles plus its DONE cycle.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH(64),
    .BASE_ADDR(1024),
    .WAIT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_access(
    input  logic        we,
    input  logic        re,
    input  logic        wb,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [3:0]  fz,
    output logic [31:0] md,
    output logic        wbo,
    output logic        mreo
  );
    fz = '0; md = '0; wbo = 1'b0; mreo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.memoryWriteEnabledIn = we;
        bus.memoryReadEnabledIn  = re;
        bus.writebackEnabledIn   = wb;
        bus.aluResultIn          = addr;
        bus.valRmIn              = data;
        bus.destinationIn        = 4'd1;
      end
      #1;
      fz[3-i] = bus.freeze;
      if (i == 3) begin
        md   = bus.memData;
        wbo  = bus.writebackEnabled;
        mreo = bus.memoryReadEnabled;
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.memoryWriteEnabledIn = 1'b0;
    bus.memoryReadEnabledIn  = 1'b0;
    bus.writebackEnabledIn   = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] fz;
    rst = 1'b0;
    bus.memoryReadEnabledIn  = 1'b1;
    bus.memoryWriteEnabledIn = 1'b0;
    bus.writebackEnabledIn   = 1'b1;
    bus.aluResultIn          = 32'd1024;
    bus.valRmIn              = '0;
    bus.destinationIn        = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.freeze !== 1'b0) begin
        errors++;
        $display("FAIL rst_freeze got %b want 0", bus.freeze);
      end
      checks++;
      if (bus.memData !== 32'h0) begin
        errors++;
        $display("FAIL rst_memData got %h want 0", bus.memData);
      end
      checks++;
      if (bus.writebackEnabled !== 1'b0) begin
        errors++;
        $display("FAIL rst_wb got %b want 0", bus.writebackEnabled);
      end
      checks++;
      if (bus.memoryReadEnabled !== 1'b0) begin
        errors++;
        $display("FAIL rst_mre got %b want 0", bus.memoryReadEnabled);
      end
    end
    fz = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      #1;
      fz[3-i] = bus.freeze;
    end
    checks++;
    if (fz !== 4'b1110) begin
      errors++;
      $display("FAIL rst_release_freeze got %b want 1110", fz);
    end
    go_idle();
  endtask

  task automatic test_store_load();
    logic [3:0] fz; logic [31:0] md; logic wbo, mreo;
    run_access(1, 0, 0, 32'd1028, 32'hDEADBEEF, fz, md, wbo, mreo);
    checks++;
    if (fz !== 4'b1110) begin
      errors++;
      $display("FAIL store_freeze got %b want 1110", fz);
    end
    run_access(0, 1, 1, 32'd1028, 32'h0, fz, md, wbo, mreo);
    checks++;
    if (fz !== 4'b1110) begin
      errors++;
      $display("FAIL load_freeze got %b want 1110", fz);
    end
    checks++;
    if (md !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_data got %h want deadbeef", md);
    end
    checks++;
    if (wbo !== 1'b1) begin
      errors++;
      $display("FAIL load_wb got %b want 1", wbo);
    end
    checks++;
    if (mreo !== 1'b1) begin
      errors++;
      $display("FAIL load_mre got %b want 1", mreo);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] fa, fb; logic [31:0] ma, mb; logic w, m;
    run_access(1, 0, 0, 32'd1024, 32'h11111111, fa, ma, w, m);
    run_access(1, 0, 0, 32'd1032, 32'h33333333, fa, ma, w, m);
    run_access(0, 1, 1, 32'd1024, 32'h0, fa, ma, w, m);
    run_access(0, 1, 1, 32'd1032, 32'h0, fb, mb, w, m);
    checks++;
    if ({fa, fb} !== 8'b11101110) begin
      errors++;
      $display("FAIL b2b_freeze got %b want 11101110", {fa, fb});
    end
    checks++;
    if (ma !== 32'h11111111) begin
      errors++;
      $display("FAIL b2b_data0 got %h want 11111111", ma);
    end
    checks++;
    if (mb !== 32'h33333333) begin
      errors++;
      $display("FAIL b2b_data1 got %h want 33333333", mb);
    end
    go_idle();
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    bus.memoryWriteEnabledIn = 1'b0;
    bus.memoryReadEnabledIn  = 1'b0;
    bus.writebackEnabledIn   = 1'b1;
    bus.aluResultIn          = 32'h12345678;
    bus.destinationIn        = 4'd5;
    #1;
    checks++;
    if (bus.freeze !== 1'b0) begin
      errors++;
      $display("FAIL nonmem_freeze got %b want 0", bus.freeze);
    end
    checks++;
    if (bus.aluResult !== 32'h12345678) begin
      errors++;
      $display("FAIL nonmem_alu got %h want 12345678", bus.aluResult);
    end
    checks++;
    if (bus.destination !== 4'd5) begin
      errors++;
      $display("FAIL nonmem_dest got %h want 5", bus.destination);
    end
    checks++;
    if (bus.writebackEnabled !== 1'b1) begin
      errors++;
      $display("FAIL nonmem_wb got %b want 1", bus.writebackEnabled);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.freeze !== 1'b0) begin
      errors++;
      $display("FAIL nonmem_freeze2 got %b want 0", bus.freeze);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_write();
    logic [3:0] fz; logic [31:0] md; logic w, m;
    run_access(1, 0, 0, 32'd1036, 32'h0, fz, md, w, m);
    go_idle();
    @(negedge clk);
    bus.memoryWriteEnabledIn = 1'b1;
    bus.aluResultIn          = 32'd1036;
    bus.valRmIn              = 32'h1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.memoryWriteEnabledIn = 1'b0;
    #1;
    checks++;
    if (bus.freeze !== 1'b0) begin
      errors++;
      $display("FAIL midrst_freeze got %b want 0", bus.freeze);
    end
    run_access(0, 1, 1, 32'd1036, 32'h0, fz, md, w, m);
    checks++;
    if (md !== 32'h0) begin
      errors++;
      $display("FAIL midrst_data got %h want 0", md);
    end
    checks++;
    if (fz !== 4'b1110) begin
      errors++;
      $display("FAIL midrst_freeze_rd got %b want 1110", fz);
    end
    go_idle();
  endtask

  task automatic test_wrap_conflict();
    logic [3:0] fz; logic [31:0] md; logic w, m;
    run_access(1, 0, 0, 32'd1280, 32'hA5, fz, md, w, m);
    run_access(0, 1, 1, 32'd1024, 32'h0, fz, md, w, m);
    checks++;
    if (md !== 32'hA5) begin
      errors++;
      $display("FAIL wrap_data got %h want a5", md);
    end
    run_access(1, 1, 1, 32'd1040, 32'h77, fz, md, w, m);
    checks++;
    if (fz !== 4'b1110) begin
      errors++;
      $display("FAIL conflict_freeze got %b want 1110", fz);
    end
    checks++;
    if (m !== 1'b0) begin
      errors++;
      $display("FAIL conflict_mre got %b want 0", m);
    end
    run_access(0, 1, 1, 32'd1040, 32'h0, fz, md, w, m);
    checks++;
    if (md !== 32'h77) begin
      errors++;
      $display("FAIL conflict_data got %h want 77", md);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_nonmem();
    test_reset_mid_write();
    test_wrap_conflict();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
